// File: rtl/ir_pkg.sv
// Shared definitions for the IR command path: frame field positions,
// repeat-filter state encoding and key codes understood by the alarm FSM.
package ir_pkg;

  localparam int IR_KEY_MSB  = 23;
  localparam int IR_KEY_LSB  = 16;
  localparam int IR_ADDR_MSB = 15;
  localparam int IR_ADDR_LSB = 0;

  typedef enum logic {
    FLT_IDLE = 1'b0,
    FLT_HELD = 1'b1
  } flt_state_e;

  localparam logic [7:0] KEY_ARM    = 8'h45;
  localparam logic [7:0] KEY_DISARM = 8'h46;
  localparam logic [7:0] KEY_PANIC  = 8'h47;

endpackage

// File: rtl/ir_cmd_fifo.sv
// Small synchronous key queue; occupancy counter drives full/empty so the
// wrapping pointers never need an extra lap bit.
module ir_cmd_fifo
  import ir_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full queue still lands when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// IR command controller: address filter, held-key repeat suppression and a
// key queue handed to the alarm FSM over valid/ready.
//
// state    | meaning
// FLT_IDLE | no recent key; holdoff parked at 0, any valid key is pushed
// FLT_HELD | holdoff running; the same key again is dropped and restarts it
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter logic [15:0] ADDR_CODE   = 16'h6B86,
  parameter int unsigned HOLDOFF_CYC = 6_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iENABLE,
  input  logic        iADDR_CHK,
  input  logic        iDATA_READY,
  input  logic [31:0] iDATA,
  output logic        oCMD_VALID,
  output logic [7:0]  oCMD_KEY,
  input  logic        iCMD_READY,
  input  logic        iCLR,
  output logic        oOVF,
  output logic [7:0]  oERR_CNT,
  output logic        oHELD
);

  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYC);

  logic          f_vld;
  logic [7:0]    f_key;
  logic [15:0]   f_addr;
  logic [7:0]    last_key;
  flt_state_e    state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic          addr_bad, repeat_hit;
  logic          accept, reload, err_evt, ovf_evt;
  logic          fifo_full, fifo_empty, pop;
  logic          ovf;
  logic [7:0]    err_cnt;

  // Inverted key byte is already validated by the receiver.
  logic unused_inv_key;
  assign unused_inv_key = ^iDATA[31:24];

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      f_vld  <= 1'b0;
      f_key  <= '0;
      f_addr <= '0;
    end else begin
      f_vld <= iDATA_READY & iENABLE;
      if (iDATA_READY & iENABLE) begin
        f_key  <= iDATA[IR_KEY_MSB:IR_KEY_LSB];
        f_addr <= iDATA[IR_ADDR_MSB:IR_ADDR_LSB];
      end
    end
  end

  assign addr_bad   = iADDR_CHK && (f_addr != ADDR_CODE);
  assign repeat_hit = (state == FLT_HELD) && (f_key == last_key);
  assign err_evt    = f_vld & addr_bad;
  assign reload     = f_vld & ~addr_bad & repeat_hit;
  assign accept     = f_vld & ~addr_bad & ~repeat_hit;

  assign oCMD_VALID = ~fifo_empty;
  assign pop        = oCMD_VALID & iCMD_READY;
  assign ovf_evt    = accept & fifo_full & ~pop;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      FLT_IDLE: begin
        hold_nxt = '0;
        if (accept) begin
          state_nxt = FLT_HELD;
          hold_nxt  = HOLD_INIT;
        end
      end
      FLT_HELD: begin
        if (accept | reload) begin
          hold_nxt = HOLD_INIT;
        end else if (hold <= HW'(1)) begin
          hold_nxt  = '0;
          state_nxt = FLT_IDLE;
        end else begin
          hold_nxt = hold - HW'(1);
        end
      end
      default: begin
        state_nxt = FLT_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state    <= FLT_IDLE;
      hold     <= '0;
      last_key <= 8'h00;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      if (accept) begin
        last_key <= f_key;
      end
    end
  end

  // Events take priority over a coincident clear.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      ovf     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (ovf_evt) begin
        ovf <= 1'b1;
      end else if (iCLR) begin
        ovf <= 1'b0;
      end
      if (iCLR) begin
        err_cnt <= err_evt ? 8'h01 : 8'h00;
      end else if (err_evt && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end
    end
  end

  assign oOVF     = ovf;
  assign oERR_CNT = err_cnt;
  assign oHELD    = (state == FLT_HELD);

  ir_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .push  (accept),
    .pop   (pop),
    .din   (f_key),
    .dout  (oCMD_KEY),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
